fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Control and address generator that drives the radix-2 DIT butterfly in an in-place N-point FFT.
- Issues one butterfly per cycle: even/odd sample read addresses for a dual-read sample RAM, twiddle ROM address, and the delayed write-back addresses for the butterfly's top and bottom results.
- Walks all log2(N) stages with a drain between stages, so no stage reads a location that the previous stage has not yet written.
- Sits between the top-level start/done handshake and the sample RAM / twiddle ROM / butterfly datapath. It owns no sample data.

## Interface
- N, 16, FFT length, power of two, at least 4
- LOG2N, 4, log2(N)
- RD_LAT, 1, sample RAM and twiddle ROM read latency, cycles
- BF_LAT, 4, butterfly input-to-output latency, cycles
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  start request, sampled only in IDLE
- o_busy  out  1  high from the cycle after start acceptance through the DONE cycle
- o_done  out  1  one-cycle pulse when the transform is complete
- o_rd_en  out  1  sample RAM / twiddle ROM read strobe
- o_rd_addr_a  out  LOG2N  even-sample read address
- o_rd_addr_b  out  LOG2N  odd-sample read address
- o_twi_addr  out  LOG2N-1  twiddle ROM index
- o_bf_en  out  1  butterfly enable, equals o_busy
- o_wr_en  out  1  write-back strobe for top and bottom results
- o_wr_addr_a  out  LOG2N  top-result write address
- o_wr_addr_b  out  LOG2N  bottom-result write address

## Operation
- Input data is already in bit-reversed order in the RAM. Output is natural order, in place.
- FSM states:
  - IDLE: i_start=1 moves to ISSUE and clears stage s and butterfly index j.
  - ISSUE: one butterfly per cycle. After j=N/2-1, j returns to 0 and the FSM moves to DRAIN.
  - DRAIN: lasts WR_DLY=RD_LAT+BF_LAT cycles. When it ends, go to ISSUE with s+1, or to DONE if s=LOG2N-1.
  - DONE: one cycle, then IDLE.
- Addressing in stage s, butterfly j:
  - h = 1<<s
  - a = ((j>>s)<<(s+1)) | (j & (h-1))
  - b = a + h
  - twiddle index k = (j & (h-1)) << (LOG2N-1-s)
  - All arithmetic is unsigned. No address exceeds N-1 and none wraps.
- All outputs are Moore-decoded from registered state and counters. o_rd_en=1 exactly in ISSUE cycles.
- Write-back path:
  - A WR_DLY-deep shift register carries {valid, a, b}.
  - o_wr_en and o_wr_addr_a/b appear exactly WR_DLY cycles after the matching o_rd_en cycle.
  - The valid bit shifts every cycle regardless of state.
- o_bf_en stays high throughout the run, so the butterfly pipeline never stalls.
- i_start while busy is ignored. It is not queued.

## Timing
- Reset values: all outputs 0, state IDLE, s=j=0, all write-pipeline valid bits 0.
- Start handshake: i_start=1 at edge E in IDLE → first ISSUE cycle is E+1, and o_busy rises then.
- Per stage: N/2 ISSUE cycles plus WR_DLY DRAIN cycles. The last write of a stage falls in the final DRAIN cycle. The next stage's first read comes one cycle later and sees the written data.
- Total: LOG2N·(N/2+WR_DLY) cycles of ISSUE/DRAIN, then 1 DONE cycle. Defaults: 52 cycles, with o_done in cycle 53 after acceptance.
- o_done and i_start in the same cycle: that start is ignored (the FSM is still in DONE). A start in the following IDLE cycle is accepted.
- Reset mid-operation: on the next edge go to IDLE, clear the write pipeline, and issue no further o_wr_en. RAM contents are undefined.

## Configuration
- FFT_SEQ_INVERSE_EN defined:
  - Adds input i_inverse (1 bit) and output o_twi_conj (1 bit, reset 0).
  - i_inverse is captured on start acceptance.
  - o_twi_conj drives the captured value while busy and is 0 in IDLE. The datapath conjugates twiddles when it is 1, giving an unscaled IFFT.
- Undefined: neither port exists and the transform is always forward.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0 and no o_wr_en pulses.
- Defaults, i_start pulse → stage 0 issues (a,b)=(0,1),(2,3)…(14,15) with twi 0. Stage 3 issues (0,8),(1,9)…(7,15) with twi 0..7. o_done in cycle 53. Exactly 32 o_wr_en pulses, each matching the read addresses 5 cycles earlier.
- At every stage boundary, the last write-address cycle immediately precedes the next stage's first read cycle. There is never an overlap or a read-after-write hazard.
- i_start held high continuously → back-to-back transforms. The second run's first ISSUE cycle is 2 cycles after the first run's o_done (DONE cycle, then start acceptance in IDLE).
- Assert rst during stage 2, ISSUE j=3 → next cycle all outputs 0, o_wr_en stays 0, and a new start runs a clean full 52+1 cycle transform.
- With FFT_SEQ_INVERSE_EN defined and i_inverse=1 at start → o_twi_conj=1 for the whole run and 0 after DONE. Addresses are identical to the forward run.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//
// Control and address generator for an in-place, radix-2 decimation-in-time FFT.
// The samples are in bit-reversed order before the transform and in natural order after it.
// The block issues one butterfly per cycle and walks all LOG2N stages. After each stage it
// waits for the write-back pipeline to drain, so a stage never reads a location that the
// previous stage has not written yet. The block holds no sample data.
//
// Optional feature: define FFT_SEQ_INVERSE_EN to add i_inverse and o_twi_conj. i_inverse is
// captured when a start is accepted. o_twi_conj then tells the datapath to conjugate the
// twiddles for the whole run.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_start       start request, sampled only while idle
//   o_busy        high from the first issue cycle through the done cycle
//   o_done        one-cycle completion pulse
//   o_rd_en       sample RAM / twiddle ROM read strobe
//   o_rd_addr_a/b even / odd sample read addresses
//   o_twi_addr    twiddle ROM index
//   o_bf_en       butterfly enable (same as o_busy)
//   o_wr_en       write-back strobe, RD_LAT+BF_LAT cycles after the matching read
//   o_wr_addr_a/b top / bottom result write addresses
//   i_inverse     (FFT_SEQ_INVERSE_EN) request an inverse transform
//   o_twi_conj    (FFT_SEQ_INVERSE_EN) conjugate twiddles during this run

module fft_stage_sequencer #(
    parameter int unsigned N      = 16,
    parameter int unsigned LOG2N  = 4,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic             i_inverse,
    output logic             o_twi_conj,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [LOG2N-2:0] o_twi_addr,
    output logic             o_bf_en,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
);

    localparam int unsigned WR_DLY = RD_LAT + BF_LAT;
    localparam int unsigned SW     = $clog2(LOG2N);
    localparam int unsigned JW     = LOG2N - 1;
    localparam int unsigned DW     = (WR_DLY > 1) ? $clog2(WR_DLY) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [JW-1:0] j_q, j_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // Sequencer state

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            j_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StIssue;
                    s_d     = '0;
                    j_d     = '0;
                    dcnt_d  = '0;
                end
            end
            StIssue: begin
                if (j_q == JW'(N / 2 - 1)) begin
                    j_d     = '0;
                    dcnt_d  = '0;
                    state_d = StDrain;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            StDrain: begin
                // Drain lasts exactly WR_DLY cycles. The last write of the stage lands in the
                // final drain cycle, one cycle before the next stage's first read.
                if (dcnt_q == DW'(WR_DLY - 1)) begin
                    dcnt_d = '0;
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = StDone;
                    end else begin
                        s_d     = s_q + 1'b1;
                        state_d = StIssue;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Butterfly addressing for stage s, butterfly j:
    //   lo = j mod h
    //   a  = (j with the low s bits cleared) shifted up by one, OR lo
    //   b  = a + h
    //   k  = lo scaled up to the N/2-entry twiddle table

    logic [LOG2N-1:0] j_ext, h, mask, lo, hi, addr_a, addr_b;
    logic [SW-1:0]    tw_sh;
    logic [JW-1:0]    tw_idx;
    logic             rd_en;

    always_comb begin
        j_ext  = {1'b0, j_q};
        h      = LOG2N'(1) << s_q;
        mask   = h - 1'b1;
        lo     = j_ext & mask;
        hi     = (j_ext >> s_q) << s_q;
        // Bit s of (hi << 1) is always 0, so adding h below never carries.
        addr_a = (hi << 1) | lo;
        addr_b = addr_a + h;
        tw_sh  = SW'(LOG2N - 1) - s_q;
        tw_idx = lo[JW-1:0] << tw_sh;
    end

    assign rd_en       = (state_q == StIssue);
    assign o_rd_en     = rd_en;
    assign o_rd_addr_a = rd_en ? addr_a : '0;
    assign o_rd_addr_b = rd_en ? addr_b : '0;
    assign o_twi_addr  = rd_en ? tw_idx : '0;
    assign o_busy      = (state_q != StIdle);
    assign o_bf_en     = o_busy;
    assign o_done      = (state_q == StDone);

    // Write-back delay line: {valid, a, b}, one entry per cycle of RD_LAT + BF_LAT.
    // The addresses are captured already gated, so an empty slot carries zeros.

    logic [WR_DLY-1:0] vld_q;
    logic [LOG2N-1:0]  pa_q [WR_DLY];
    logic [LOG2N-1:0]  pb_q [WR_DLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(WR_DLY); i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            pa_q[0]  <= o_rd_addr_a;
            pb_q[0]  <= o_rd_addr_b;
            for (int i = 1; i < int'(WR_DLY); i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pb_q[i]  <= pb_q[i-1];
            end
        end
    end

    assign o_wr_en     = vld_q[WR_DLY-1];
    assign o_wr_addr_a = pa_q[WR_DLY-1];
    assign o_wr_addr_b = pb_q[WR_DLY-1];

`ifdef FFT_SEQ_INVERSE_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == StIdle && i_start) begin
            inv_q <= i_inverse;
        end
    end

    assign o_twi_conj = o_busy & inv_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer with the default parameters (N=16).
// The reference model derives every output from the number of cycles since start acceptance,
// using plain arithmetic on stage, butterfly and write-back position.

module tb_fft_stage_sequencer;

    localparam int N      = 16;
    localparam int LOG2N  = 4;
    localparam int TW     = LOG2N - 1;
    localparam int RD_LAT = 1;
    localparam int BF_LAT = 4;
    localparam int WR     = RD_LAT + BF_LAT;
    localparam int HALF   = N / 2;
    localparam int SC     = HALF + WR;
    localparam int TOTAL  = LOG2N * SC;
`ifdef FFT_SEQ_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_inverse = 1'b0;
    logic             twi_conj;
    logic             o_busy, o_done, o_rd_en, o_bf_en, o_wr_en;
    logic [LOG2N-1:0] o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
    logic [TW-1:0]    o_twi_addr;

    fft_stage_sequencer #(
        .N      (N),
        .LOG2N  (LOG2N),
        .RD_LAT (RD_LAT),
        .BF_LAT (BF_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
`ifdef FFT_SEQ_INVERSE_EN
        .i_inverse   (i_inverse),
        .o_twi_conj  (twi_conj),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rd_en     (o_rd_en),
        .o_rd_addr_a (o_rd_addr_a),
        .o_rd_addr_b (o_rd_addr_b),
        .o_twi_addr  (o_twi_addr),
        .o_bf_en     (o_bf_en),
        .o_wr_en     (o_wr_en),
        .o_wr_addr_a (o_wr_addr_a),
        .o_wr_addr_b (o_wr_addr_b)
    );

`ifndef FFT_SEQ_INVERSE_EN
    assign twi_conj = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             rd;
        logic [LOG2N-1:0] ra;
        logic [LOG2N-1:0] rb;
        logic [TW-1:0]    tw;
        logic             bf;
        logic             wr;
        logic [LOG2N-1:0] wa;
        logic [LOG2N-1:0] wb;
        logic             conj;
    } outs_t;

    typedef struct {
        int c;
        bit rd;
        int a;
        int b;
        int tw;
        bit wr;
        int wa;
        int wb;
        bit done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int m_c    = 0;      // 0 = idle, k = k-th cycle after start acceptance
    bit m_inv  = 1'b0;
    int wr_cnt = 0;

    function automatic outs_t model_out(int c, bit inv);
        outs_t o;
        int    idx, st, pos, h, j;
        o = '0;
        if (c == 0) return o;
        o.busy = 1'b1;
        o.bf   = 1'b1;
        o.conj = inv;
        if (c == TOTAL + 1) begin
            o.done = 1'b1;
            return o;
        end
        idx = c - 1;
        st  = idx / SC;
        pos = idx % SC;
        h   = 2 ** st;
        if (pos < HALF) begin
            j    = pos;
            o.rd = 1'b1;
            o.ra = LOG2N'(2 * h * (j / h) + j % h);
            o.rb = LOG2N'(2 * h * (j / h) + j % h + h);
            o.tw = TW'((j % h) * (N / (2 * h)));
        end
        if (pos >= WR) begin
            j    = pos - WR;
            o.wr = 1'b1;
            o.wa = LOG2N'(2 * h * (j / h) + j % h);
            o.wb = LOG2N'(2 * h * (j / h) + j % h + h);
        end
        return o;
    endfunction

    function automatic outs_t dut_out();
        outs_t o;
        o.busy = o_busy;
        o.done = o_done;
        o.rd   = o_rd_en;
        o.ra   = o_rd_addr_a;
        o.rb   = o_rd_addr_b;
        o.tw   = o_twi_addr;
        o.bf   = o_bf_en;
        o.wr   = o_wr_en;
        o.wa   = o_wr_addr_a;
        o.wb   = o_wr_addr_b;
        o.conj = twi_conj;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got busy=%b done=%b rd=%b ra=%0d rb=%0d tw=%0d bf=%b wr=%b wa=%0d wb=%0d conj=%b, expected busy=%b done=%b rd=%b ra=%0d rb=%0d tw=%0d bf=%b wr=%b wa=%0d wb=%0d conj=%b",
                     name, $time, act.busy, act.done, act.rd, act.ra, act.rb, act.tw, act.bf,
                     act.wr, act.wa, act.wb, act.conj, exp.busy, exp.done, exp.rd, exp.ra,
                     exp.rb, exp.tw, exp.bf, exp.wr, exp.wa, exp.wb, exp.conj);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance one clock, update the reference model from the inputs seen at the edge,
    // then compare every output 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_c = 0;
        end else if (m_c == 0) begin
            if (i_start) begin
                m_c   = 1;
                m_inv = INV_EN && i_inverse;
            end
        end else if (m_c == TOTAL + 1) begin
            m_c = 0;
        end else begin
            m_c++;
        end
        #1;
        if (o_wr_en) wr_cnt++;
        check_outs($sformatf("cycle_c%0d", m_c), dut_out(), model_out(m_c, m_inv));
    endtask

    task automatic run_until_idle(input string name);
        int guard;
        guard = 0;
        while (m_c != 0 && guard < 200) begin
            cycle();
            guard++;
        end
        check_int({name, "_reaches_idle"}, m_c, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int    n;
        outs_t e;

        // Hand-computed checkpoints for a forward run from cycle 1 (first issue).
        // Fields: c, rd, a, b, tw, wr, wa, wb, done.
        vecs.push_back('{1,  1, 0,  1,  0, 0, 0,  0,  0});
        vecs.push_back('{2,  1, 2,  3,  0, 0, 0,  0,  0});
        vecs.push_back('{6,  1, 10, 11, 0, 1, 0,  1,  0});
        vecs.push_back('{8,  1, 14, 15, 0, 1, 4,  5,  0});
        vecs.push_back('{9,  0, 0,  0,  0, 1, 6,  7,  0});
        vecs.push_back('{13, 0, 0,  0,  0, 1, 14, 15, 0});
        vecs.push_back('{14, 1, 0,  2,  0, 0, 0,  0,  0});
        vecs.push_back('{15, 1, 1,  3,  4, 0, 0,  0,  0});
        vecs.push_back('{16, 1, 4,  6,  0, 0, 0,  0,  0});
        vecs.push_back('{30, 1, 3,  7,  6, 0, 0,  0,  0});
        vecs.push_back('{35, 0, 0,  0,  0, 1, 3,  7,  0});
        vecs.push_back('{40, 1, 0,  8,  0, 0, 0,  0,  0});
        vecs.push_back('{41, 1, 1,  9,  1, 0, 0,  0,  0});
        vecs.push_back('{47, 1, 7,  15, 7, 1, 2,  10, 0});
        vecs.push_back('{52, 0, 0,  0,  0, 1, 7,  15, 0});
        vecs.push_back('{53, 0, 0,  0,  0, 0, 0,  0,  1});

        // Reset, then 10 idle cycles: all outputs zero, no writes.
        rst = 1'b1;
        cycle();
        cycle();
        rst    = 1'b0;
        wr_cnt = 0;
        repeat (10) cycle();
        check_int("idle_no_writes", wr_cnt, 0);

        // Forward run against the table.
        wr_cnt  = 0;
        i_start = 1'b1;
        cycle();
        i_start = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            n = 0;
            while (m_c < vecs[i].c && n < 100) begin
                cycle();
                n++;
            end
            e      = '0;
            e.busy = 1'b1;
            e.bf   = 1'b1;
            e.done = vecs[i].done;
            e.rd   = vecs[i].rd;
            e.ra   = LOG2N'(vecs[i].a);
            e.rb   = LOG2N'(vecs[i].b);
            e.tw   = TW'(vecs[i].tw);
            e.wr   = vecs[i].wr;
            e.wa   = LOG2N'(vecs[i].wa);
            e.wb   = LOG2N'(vecs[i].wb);
            check_outs($sformatf("vec_c%0d", vecs[i].c), dut_out(), e);
        end
        run_until_idle("table_run");
        check_int("table_run_wr_pulses", wr_cnt, LOG2N * HALF);

        // Start held high: the second run starts issuing 2 cycles after o_done.
        i_start = 1'b1;
        n = 0;
        cycle();
        while (!o_done && n < 200) begin
            cycle();
            n++;
        end
        check_int("b2b_first_done", int'(o_done), 1);
        cycle();
        check_int("b2b_idle_after_done", int'(o_busy), 0);
        cycle();
        check_int("b2b_second_issue", int'(o_rd_en), 1);
        i_start = 1'b0;
        run_until_idle("b2b");

        // Reset in stage 2, butterfly j=3 (cycle 30).
        i_start = 1'b1;
        cycle();
        i_start = 1'b0;
        n = 0;
        while (m_c < 30 && n < 100) begin
            cycle();
            n++;
        end
        check_int("pre_rst_addr_a", int'(o_rd_addr_a), 3);
        check_int("pre_rst_addr_b", int'(o_rd_addr_b), 7);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_outs("rst_all_zero", dut_out(), '0);
        wr_cnt = 0;
        repeat (10) cycle();
        check_int("rst_no_writes", wr_cnt, 0);

        // A clean full run after that reset, with inverse requested.
        wr_cnt    = 0;
        i_start   = 1'b1;
        i_inverse = 1'b1;
        cycle();
        i_start   = 1'b0;
        i_inverse = 1'b0;
        n = 1;
        while (!o_done && n < 200) begin
            cycle();
            n++;
        end
        check_int("post_rst_done_cycle", n, TOTAL + 1);
        check_int("post_rst_wr_pulses", wr_cnt, LOG2N * HALF);
`ifdef FFT_SEQ_INVERSE_EN
        check_int("conj_in_done", int'(twi_conj), 1);
`endif
        cycle();
`ifdef FFT_SEQ_INVERSE_EN
        check_int("conj_after_done", int'(twi_conj), 0);
`endif

        // Random starts, inverse requests and occasional resets.
        repeat (3000) begin
            i_start   = ($urandom_range(0, 3) == 0);
            i_inverse = $urandom_range(0, 1) != 0;
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst     = 1'b0;
        i_start = 1'b0;
        run_until_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
